mem_data_unit: RTL and testbench
================================

# mem_data_unit

MEM-stage data memory and load/store formatter. It consumes the control and data fields that the EX/MEM pipeline register presents: access type, size enables, signedness, ALU address and store data. It performs byte-, halfword- and word-granular stores. It returns sign- or zero-extended load data toward MEM/WB. A valid/ready dump engine streams the full memory contents to the debug unit after the processor halts.

## Interface
- NB_DATA, 32, data/address width
- NB_ADDR, 7, word-index width; memory depth 2^NB_ADDR words (default 128 words / 512 bytes)
- i_clock  in  1  system clock; all state updates on rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_mem_read  in  1  load in MEM stage
- i_mem_write  in  1  store in MEM stage
- i_signed  in  1  1: sign-extend loads, 0: zero-extend
- i_byte_en  in  1  byte access
- i_halfword_en  in  1  halfword access
- i_word_en  in  1  word access
- i_addr  in  NB_DATA  byte address (ALU result)
- i_wr_data  in  NB_DATA  store data (register rt)
- o_rd_data  out  NB_DATA  formatted load data
- o_misaligned  out  1  current access violates alignment
- i_dump_start  in  1  start memory dump (one-cycle pulse)
- i_dump_ready  in  1  debug unit accepts current word
- o_dump_valid  out  1  dump word presented
- o_dump_addr  out  NB_ADDR  word index of presented word
- o_dump_data  out  NB_DATA  word contents
- o_dump_busy  out  1  dump in progress
- o_dump_done  out  1  one-cycle pulse after last word accepted

## Operation
- Address decode:
  - word index = i_addr[NB_ADDR+1:2], lane = i_addr[1:0].
  - Address bits above NB_ADDR+1 are ignored, so addresses wrap modulo memory size.
- Size priority when several enables are high: word > halfword > byte. If no enable is high, there is no access and o_rd_data = 0.
- Alignment (all combinational):
  - Halfword requires lane[0]=0.
  - Word requires lane=0.
  - Byte is always aligned.
  - o_misaligned = (i_mem_read | i_mem_write) & violation.
- Stores (i_mem_write=1, aligned, not dumping):
  - Byte: writes i_wr_data[7:0] into byte lane `lane`.
  - Halfword: writes i_wr_data[15:0] into bits [15:0] when lane=0, or into [31:16] when lane=2.
  - Word: writes all 32 bits.
  - Other bytes of the word are preserved.
  - Misaligned stores are suppressed.
- Loads:
  - Read is combinational from the array.
  - The selected byte or halfword is extended per i_signed. Word is passed unchanged.
  - A misaligned load, or i_mem_read=0, gives o_rd_data = 0.
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE → DUMP on i_dump_start. Index is cleared to 0.
  - DUMP: o_dump_valid=1, o_dump_addr=index, o_dump_data=mem[index]. On valid&ready, index increments.
  - Acceptance at index 2^NB_ADDR−1 goes to DONE.
  - DONE: o_dump_done=1 for one cycle, then IDLE.
  - i_dump_start outside IDLE is ignored.
- While in DUMP or DONE, i_mem_write is ignored; the pipeline is halted. Loads still function.

## Timing
- Reset:
  - Clears all memory words to 0.
  - FSM → IDLE, index → 0.
  - o_dump_valid/busy/done = 0, o_dump_addr = 0, o_rd_data = 0 (no access asserted).
- Store takes effect at the rising edge where it is presented. A load of the same address in the next cycle returns the new data.
- Load latency is 0 cycles (combinational). o_misaligned is also combinational.
- Dump:
  - o_dump_valid rises one cycle after the i_dump_start edge.
  - One word per cycle with ready held high: 2^NB_ADDR cycles in DUMP, then 1 DONE cycle.
  - o_dump_busy=1 in DUMP and DONE.
  - Data/addr are held stable while valid & !ready.
- Reset mid-dump: aborts to IDLE on that edge with no done pulse, and memory is cleared.
- Simultaneous i_dump_start and i_mem_write in IDLE: the store completes on that edge. The dump starts next cycle and sees the new data.

## Test plan
- Reset then word load at 0x00: o_rd_data=0x00000000, o_misaligned=0. Store word 0x8081F0F1 at 0x04; next cycle, word load at 0x04 = 0x8081F0F1.
- Byte/halfword formatting (memory at 0x04 = 0x8081F0F1):
  - Signed byte load at 0x05 = 0xFFFFFFF0; unsigned = 0x000000F0.
  - Signed halfword at 0x06 = 0xFFFF8081.
  - Byte store 0x55 at 0x07, then word load = 0x5581F0F1.
- Misalignment: halfword store at 0x09 and word store at 0x0A both give o_misaligned=1. A word load at 0x08 afterwards still returns the prior value (0). Misaligned word load returns 0.
- Wrap: word store 0x12345678 at 0x204 (default params); word load at 0x004 = 0x12345678.
- Dump with backpressure:
  - Preload word 3 = 0xDEADBEEF, pulse start, toggle ready every other cycle.
  - Every index 0..127 is delivered exactly once, in order; index 3 carries 0xDEADBEEF.
  - o_dump_done pulses once.
  - A store attempted mid-dump leaves memory unchanged.
- Reset at dump index 40: next cycle FSM is IDLE, o_dump_valid=0, no done pulse, and a load at 0x0C = 0.

Source files
------------

// File: rtl/mem_data_unit.sv
// MEM-stage data memory with byte/halfword/word load-store formatting and a post-halt dump streamer.
// Latency: loads and misalignment flag are combinational; stores commit on the presenting edge.
// Backpressure: dump holds addr/data while valid & !ready; stores are ignored while the dump runs.
module mem_data_unit #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 7
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic               i_signed,
    input  logic               i_byte_en,
    input  logic               i_halfword_en,
    input  logic               i_word_en,
    input  logic [NB_DATA-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    output logic [NB_DATA-1:0] o_rd_data,
    output logic               o_misaligned,
    input  logic               i_dump_start,
    input  logic               i_dump_ready,
    output logic               o_dump_valid,
    output logic [NB_ADDR-1:0] o_dump_addr,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_busy,
    output logic               o_dump_done
);
    localparam int DEPTH = 1 << NB_ADDR;

    typedef enum logic [1:0] {ST_IDLE, ST_DUMP, ST_DONE} state_t;

    logic [NB_DATA-1:0] mem [DEPTH];
    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] idx_q;

    logic [NB_ADDR-1:0] word_idx;
    logic [1:0]         lane;
    logic               is_word, is_half, is_byte, violation, store_en;
    logic [NB_DATA-1:0] rd_word, wr_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic               unused_addr_bits;

    // Upper address bits are dropped so accesses wrap modulo the array size.
    assign word_idx         = i_addr[NB_ADDR+1:2];
    assign lane             = i_addr[1:0];
    assign unused_addr_bits = ^i_addr[NB_DATA-1:NB_ADDR+2];

    assign is_word   = i_word_en;
    assign is_half   = !i_word_en && i_halfword_en;
    assign is_byte   = !i_word_en && !i_halfword_en && i_byte_en;
    assign violation = (is_half && lane[0]) || (is_word && (lane != 2'b00));

    assign o_misaligned = (i_mem_read || i_mem_write) && violation;
    assign store_en     = i_mem_write && !violation && (is_word || is_half || is_byte)
                          && (state_q == ST_IDLE);

    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = lane[1] ? rd_word[16 +: 16] : rd_word[0 +: 16];

    always_comb begin
        o_rd_data = '0;
        if (i_mem_read && !violation) begin
            if (is_word)
                o_rd_data = rd_word;
            else if (is_half)
                o_rd_data = {{(NB_DATA-16){i_signed && rd_half[15]}}, rd_half};
            else if (is_byte)
                o_rd_data = {{(NB_DATA-8){i_signed && rd_byte[7]}}, rd_byte};
        end
    end

    // Read-modify-write merge keeps the untouched lanes of the word.
    always_comb begin
        wr_word = rd_word;
        if (is_word)
            wr_word = i_wr_data;
        else if (is_half)
            wr_word[{lane[1], 4'b0000} +: 16] = i_wr_data[15:0];
        else if (is_byte)
            wr_word[{lane, 3'b000} +: 8] = i_wr_data[7:0];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (store_en) begin
            mem[word_idx] <= wr_word;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && i_dump_start)
                idx_q <= '0;
            else if (state_q == ST_DUMP && i_dump_ready)
                idx_q <= idx_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_dump_start) state_d = ST_DUMP;
            ST_DUMP: if (i_dump_ready && (&idx_q)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_dump_valid = (state_q == ST_DUMP);
        o_dump_busy  = (state_q != ST_IDLE);
        o_dump_done  = (state_q == ST_DONE);
        o_dump_addr  = idx_q;
        o_dump_data  = mem[idx_q];
    end
endmodule

// File: tb/tb_mem_data_unit.sv
// Directed bench for mem_data_unit: load/store formatting, alignment, wrap, dump streaming and reset abort.
module tb_mem_data_unit;
    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 7;

    logic               i_clock = 1'b0;
    logic               i_reset;
    logic               i_mem_read, i_mem_write, i_signed;
    logic               i_byte_en, i_halfword_en, i_word_en;
    logic [NB_DATA-1:0] i_addr, i_wr_data;
    logic [NB_DATA-1:0] o_rd_data;
    logic               o_misaligned;
    logic               i_dump_start, i_dump_ready;
    logic               o_dump_valid, o_dump_busy, o_dump_done;
    logic [NB_ADDR-1:0] o_dump_addr;
    logic [NB_DATA-1:0] o_dump_data;

    int vectors = 0;
    int miscompares = 0;

    mem_data_unit #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_signed(i_signed),
        .i_byte_en(i_byte_en), .i_halfword_en(i_halfword_en), .i_word_en(i_word_en),
        .i_addr(i_addr), .i_wr_data(i_wr_data),
        .o_rd_data(o_rd_data), .o_misaligned(o_misaligned),
        .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready),
        .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
        .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done)
    );

    always #5 i_clock = ~i_clock;

    task automatic drive(input logic rd, input logic wr, input logic sgn, input logic b,
                         input logic h, input logic w, input logic [31:0] addr,
                         input logic [31:0] data);
        i_mem_read = rd; i_mem_write = wr; i_signed = sgn;
        i_byte_en = b; i_halfword_en = h; i_word_en = w;
        i_addr = addr; i_wr_data = data;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_dump_start = 1'b0; i_dump_ready = 1'b0;
        idle();
        repeat (2) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;
        #1;
        vectors++;
        if ({o_dump_valid, o_dump_busy, o_dump_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_dump_flags: got %b want 000", {o_dump_valid, o_dump_busy, o_dump_done});
        end
        vectors++;
        if (o_dump_addr !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_dump_addr: got %0d want 0", o_dump_addr);
        end
        vectors++;
        if (o_rd_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rd_noaccess: got %h want 00000000", o_rd_data);
        end
        drive(1, 0, 0, 0, 0, 1, 32'h00, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'h0 || o_misaligned !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_load0: got %h/%b want 00000000/0", o_rd_data, o_misaligned);
        end
    endtask

    task automatic test_word();
        @(negedge i_clock);
        drive(0, 1, 0, 0, 0, 1, 32'h04, 32'h8081F0F1);
        @(negedge i_clock);
        drive(1, 0, 0, 0, 0, 1, 32'h04, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'h8081F0F1) begin
            miscompares++;
            $display("FAIL word_load_04: got %h want 8081f0f1", o_rd_data);
        end
    endtask

    task automatic test_format();
        @(negedge i_clock);
        drive(1, 0, 1, 1, 0, 0, 32'h05, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'hFFFFFFF0) begin
            miscompares++;
            $display("FAIL sbyte_05: got %h want fffffff0", o_rd_data);
        end
        drive(1, 0, 0, 1, 0, 0, 32'h05, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'h000000F0) begin
            miscompares++;
            $display("FAIL ubyte_05: got %h want 000000f0", o_rd_data);
        end
        drive(1, 0, 1, 0, 1, 0, 32'h06, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'hFFFF8081) begin
            miscompares++;
            $display("FAIL shalf_06: got %h want ffff8081", o_rd_data);
        end
        drive(1, 0, 0, 0, 1, 0, 32'h04, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'h0000F0F1) begin
            miscompares++;
            $display("FAIL uhalf_04: got %h want 0000f0f1", o_rd_data);
        end
        // All three enables high: word access wins.
        drive(1, 0, 1, 1, 1, 1, 32'h04, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'h8081F0F1) begin
            miscompares++;
            $display("FAIL priority_word: got %h want 8081f0f1", o_rd_data);
        end
        @(negedge i_clock);
        drive(0, 1, 0, 1, 0, 0, 32'h07, 32'hAAAAAA55);
        @(negedge i_clock);
        drive(1, 0, 0, 0, 0, 1, 32'h04, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'h5581F0F1) begin
            miscompares++;
            $display("FAIL byte_store_07: got %h want 5581f0f1", o_rd_data);
        end
        drive(1, 0, 1, 1, 0, 0, 32'h07, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'h00000055) begin
            miscompares++;
            $display("FAIL sbyte_07_pos: got %h want 00000055", o_rd_data);
        end
    endtask

    task automatic test_misaligned();
        @(negedge i_clock);
        drive(0, 1, 0, 0, 1, 0, 32'h09, 32'h0000AAAA);
        #1;
        vectors++;
        if (o_misaligned !== 1'b1) begin
            miscompares++;
            $display("FAIL mis_half_09: got %b want 1", o_misaligned);
        end
        @(negedge i_clock);
        drive(0, 1, 0, 0, 0, 1, 32'h0A, 32'hBBBBBBBB);
        #1;
        vectors++;
        if (o_misaligned !== 1'b1) begin
            miscompares++;
            $display("FAIL mis_word_0A: got %b want 1", o_misaligned);
        end
        @(negedge i_clock);
        drive(1, 0, 0, 0, 0, 1, 32'h08, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'h0 || o_misaligned !== 1'b0) begin
            miscompares++;
            $display("FAIL mis_store_suppressed: got %h/%b want 00000000/0", o_rd_data, o_misaligned);
        end
        drive(1, 0, 0, 0, 0, 1, 32'h06, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'h0 || o_misaligned !== 1'b1) begin
            miscompares++;
            $display("FAIL mis_word_load_06: got %h/%b want 00000000/1", o_rd_data, o_misaligned);
        end
        drive(1, 0, 0, 1, 0, 0, 32'h05, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'h000000F0 || o_misaligned !== 1'b0) begin
            miscompares++;
            $display("FAIL byte_any_lane: got %h/%b want 000000f0/0", o_rd_data, o_misaligned);
        end
    endtask

    task automatic test_wrap();
        @(negedge i_clock);
        drive(0, 1, 0, 0, 0, 1, 32'h204, 32'h12345678);
        @(negedge i_clock);
        drive(1, 0, 0, 0, 0, 1, 32'h004, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'h12345678) begin
            miscompares++;
            $display("FAIL wrap_204: got %h want 12345678", o_rd_data);
        end
    endtask

    task automatic test_dump_backpressure();
        int exp_idx = 0;
        int dones = 0;
        logic prev_stall = 1'b0;
        logic [NB_ADDR-1:0] prev_addr = '0;
        logic [NB_DATA-1:0] prev_data = '0;
        logic [NB_DATA-1:0] exp_data;
        // Store to word 3 on the same edge as the start pulse; the dump must see it.
        @(negedge i_clock);
        drive(0, 1, 0, 0, 0, 1, 32'h0C, 32'hDEADBEEF);
        i_dump_start = 1'b1;
        @(negedge i_clock);
        i_dump_start = 1'b0;
        i_dump_ready = 1'b0;
        drive(0, 1, 0, 0, 0, 1, 32'h10, 32'hCAFEF00D);
        #1;
        vectors++;
        if (o_dump_valid !== 1'b1 || o_dump_addr !== 7'd0) begin
            miscompares++;
            $display("FAIL dump_start: valid %b addr %0d want 1/0", o_dump_valid, o_dump_addr);
        end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (cyc > 0) begin
                @(negedge i_clock);
                idle();
                i_dump_ready = ((cyc % 2) == 1);
                #1;
            end
            if (o_dump_done) dones++;
            if (prev_stall) begin
                vectors++;
                if (o_dump_addr !== prev_addr || o_dump_data !== prev_data) begin
                    miscompares++;
                    $display("FAIL dump_hold: got %0d/%h want %0d/%h", o_dump_addr, o_dump_data, prev_addr, prev_data);
                end
            end
            if (o_dump_valid && i_dump_ready) begin
                case (exp_idx)
                    1:       exp_data = 32'h12345678;
                    3:       exp_data = 32'hDEADBEEF;
                    default: exp_data = 32'h0;
                endcase
                vectors++;
                if (int'(o_dump_addr) !== exp_idx || o_dump_data !== exp_data) begin
                    miscompares++;
                    $display("FAIL dump_word: got %0d/%h want %0d/%h", o_dump_addr, o_dump_data, exp_idx, exp_data);
                end
                exp_idx++;
            end
            prev_stall = o_dump_valid && !i_dump_ready;
            prev_addr  = o_dump_addr;
            prev_data  = o_dump_data;
            if (!o_dump_busy) break;
        end
        vectors++;
        if (exp_idx != 128 || dones != 1 || o_dump_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL dump_summary: words %0d dones %0d busy %b want 128/1/0", exp_idx, dones, o_dump_busy);
        end
        drive(1, 0, 0, 0, 0, 1, 32'h10, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'h0) begin
            miscompares++;
            $display("FAIL dump_store_blocked: got %h want 00000000", o_rd_data);
        end
        drive(1, 0, 0, 0, 0, 1, 32'h0C, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL start_with_store: got %h want deadbeef", o_rd_data);
        end
    endtask

    task automatic test_reset_mid_dump();
        logic found = 1'b0;
        int dones = 0;
        @(negedge i_clock);
        idle();
        i_dump_start = 1'b1;
        i_dump_ready = 1'b1;
        @(negedge i_clock);
        i_dump_start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            #1;
            if (o_dump_valid && o_dump_addr == 7'd40) begin
                found = 1'b1;
                break;
            end
            @(negedge i_clock);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL reach_idx40: got addr %0d want 40", o_dump_addr);
        end
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        #1;
        vectors++;
        if ({o_dump_valid, o_dump_busy, o_dump_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_flags: got %b want 000", {o_dump_valid, o_dump_busy, o_dump_done});
        end
        drive(1, 0, 0, 0, 0, 1, 32'h0C, 32'h0);
        #1;
        vectors++;
        if (o_rd_data !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_mem_cleared: got %h want 00000000", o_rd_data);
        end
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge i_clock);
            #1;
            if (o_dump_done) dones++;
        end
        vectors++;
        if (dones != 0 || o_dump_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done: dones %0d busy %b want 0/0", dones, o_dump_busy);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_format();
        test_misaligned();
        test_wrap();
        test_dump_backpressure();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
